seq_num_extractor: RTL and testbench

SEQ_NUM_EXTRACTOR -- requirements
Module: seq_num_extractor

---
 rtl/fix_pkg.sv | 26 ++
 rtl/ascii_dec_accum.sv | 39 +++
 rtl/seq_num_extractor.sv | 173 +++++++++++++++++
 tb/tb_seq_num_extractor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared FIX-parsing constants, FSM state type and error codes for the
// MsgSeqNum extractor.
package fix_pkg;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ  = 8'h3D;
  localparam int unsigned TAG_MSGSEQNUM = 34;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    VALUE_SEQ,
    SKIP,
    FOUND
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISSING  = 2'd1;
  localparam logic [1:0] ERR_FORMAT   = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// Decimal accumulator: value = value*10 + digit, with a sticky overflow flag.
// Once overflowed the value freezes so later digits cannot wrap it back.
module ascii_dec_accum #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] value,
  output logic             overflow
);

  logic [WIDTH+3:0] base;
  logic [WIDTH+3:0] next_value;

  // Four spare bits are enough because 10 * (2^WIDTH - 1) + 9 < 2^(WIDTH+4).
  assign base       = clear ? '0 : {4'b0000, value};
  assign next_value = (base << 3) + (base << 1) + {{WIDTH{1'b0}}, digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value    <= '0;
      overflow <= 1'b0;
    end else if (digit_valid) begin
      if ((overflow && !clear) || (|next_value[WIDTH+3:WIDTH])) begin
        overflow <= 1'b1;
      end else begin
        value    <= next_value[WIDTH-1:0];
        overflow <= 1'b0;
      end
    end else if (clear) begin
      value    <= '0;
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_num_extractor.sv
// Scans a FIX byte stream for the first tag 34 (MsgSeqNum) of each message,
// decodes it and compares it against the expected sequence number.
module seq_num_extractor
  import fix_pkg::*;
#(
  parameter int SEQ_WIDTH  = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  input  logic                 msg_start_i,
  input  logic                 msg_last_i,
  input  logic [SEQ_WIDTH-1:0] expected_seq_num_i,
  output logic                 receive_new_message_o,
  output logic [SEQ_WIDTH-1:0] seq_num_o,
  output logic                 seq_valid_o,
  output logic                 seq_ok_o,
  output logic                 seq_gap_o,
  output logic                 seq_low_o,
  output logic [1:0]           seq_err_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 2);

  state_t               state;
  state_t               eff_state;
  logic [CNT_W-1:0]     digit_cnt;
  logic [15:0]          tag_value;
  logic                 tag_ovf;
  logic [SEQ_WIDTH-1:0] value;
  logic                 value_ovf;
  logic                 digit_b;
  logic                 start_now;
  logic                 both;
  logic                 tag_match;
  logic                 tag_clear;
  logic                 tag_digit;
  logic                 value_digit;
  logic                 emit;
  logic [1:0]           emit_code;
  logic [1:0]           field_err;

  // A start byte is also the first tag byte, so it is processed as if in TAG.
  assign digit_b     = is_digit(byte_i);
  assign start_now   = byte_valid_i && msg_start_i;
  assign both        = msg_start_i && msg_last_i;
  assign eff_state   = msg_start_i ? TAG : state;
  assign tag_match   = !msg_start_i && !tag_ovf && (tag_value == 16'(TAG_MSGSEQNUM));
  assign tag_clear   = start_now || (byte_valid_i && state == SKIP && byte_i == SOH);
  assign tag_digit   = byte_valid_i && !both && eff_state == TAG && digit_b;
  assign value_digit = byte_valid_i && !msg_start_i && state == VALUE_SEQ && digit_b;

  ascii_dec_accum #(.WIDTH(16)) u_tag_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (tag_clear),
    .digit_valid (tag_digit),
    .digit       (byte_i[3:0]),
    .value       (tag_value),
    .overflow    (tag_ovf)
  );

  ascii_dec_accum #(.WIDTH(SEQ_WIDTH)) u_value_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_now),
    .digit_valid (value_digit),
    .digit       (byte_i[3:0]),
    .value       (value),
    .overflow    (value_ovf)
  );

  always_comb begin
    field_err = ERR_NONE;
    if (byte_i != SOH || digit_cnt == '0)
      field_err = ERR_FORMAT;
    else if (value_ovf || digit_cnt > CNT_W'(MAX_DIGITS))
      field_err = ERR_OVERFLOW;

    emit      = 1'b0;
    emit_code = ERR_NONE;
    if (byte_valid_i) begin
      if (both) begin
        emit      = 1'b1;
        emit_code = ERR_MISSING;
      end else begin
        case (eff_state)
          TAG, SKIP: begin
            emit      = msg_last_i;
            emit_code = ERR_MISSING;
          end
          VALUE_SEQ: begin
            // A terminating byte yields its own result even when it is also last.
            if (!digit_b) begin
              emit      = 1'b1;
              emit_code = field_err;
            end else if (msg_last_i) begin
              emit      = 1'b1;
              emit_code = ERR_MISSING;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      digit_cnt             <= '0;
      receive_new_message_o <= 1'b0;
      seq_valid_o           <= 1'b0;
      seq_num_o             <= '0;
      seq_ok_o              <= 1'b0;
      seq_gap_o             <= 1'b0;
      seq_low_o             <= 1'b0;
      seq_err_o             <= ERR_NONE;
    end else begin
      receive_new_message_o <= start_now;
      seq_valid_o           <= emit;
      if (emit) begin
        seq_err_o <= emit_code;
        if (emit_code == ERR_NONE) begin
          seq_num_o <= value;
          seq_ok_o  <= (value == expected_seq_num_i);
          seq_gap_o <= (value > expected_seq_num_i);
          seq_low_o <= (value < expected_seq_num_i);
        end else begin
          seq_ok_o  <= 1'b0;
          seq_gap_o <= 1'b0;
          seq_low_o <= 1'b0;
        end
      end

      if (start_now)
        digit_cnt <= '0;
      else if (value_digit && digit_cnt <= CNT_W'(MAX_DIGITS))
        digit_cnt <= digit_cnt + CNT_W'(1);

      if (byte_valid_i) begin
        if (both) begin
          state <= IDLE;
        end else begin
          case (eff_state)
            IDLE: ;
            TAG: begin
              if (msg_last_i)          state <= IDLE;
              else if (digit_b)        state <= TAG;
              else if (byte_i == EQ)   state <= tag_match ? VALUE_SEQ : SKIP;
              else                     state <= SKIP;
            end
            SKIP: begin
              if (msg_last_i)          state <= IDLE;
              else if (byte_i == SOH)  state <= TAG;
            end
            VALUE_SEQ: begin
              if (msg_last_i)          state <= IDLE;
              else if (!digit_b)       state <= FOUND;
            end
            FOUND: begin
              if (msg_last_i)          state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_num_extractor.sv
// Randomised bench for seq_num_extractor: each message is parsed by a
// field-level reference model that predicts the result byte and outcome.
module tb_seq_num_extractor;

  localparam int SW = 32;
  localparam int MD = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_d = 8'h00;
  logic          msg_start = 1'b0;
  logic          msg_last = 1'b0;
  logic [SW-1:0] expected = '0;
  logic          rnm;
  logic [SW-1:0] seq_num;
  logic          seq_valid;
  logic          seq_ok;
  logic          seq_gap;
  logic          seq_low;
  logic [1:0]    seq_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [SW-1:0] model_seq = '0;

  seq_num_extractor #(.SEQ_WIDTH(SW), .MAX_DIGITS(MD)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .byte_valid_i          (byte_valid),
    .byte_i                (byte_d),
    .msg_start_i           (msg_start),
    .msg_last_i            (msg_last),
    .expected_seq_num_i    (expected),
    .receive_new_message_o (rnm),
    .seq_num_o             (seq_num),
    .seq_valid_o           (seq_valid),
    .seq_ok_o              (seq_ok),
    .seq_gap_o             (seq_gap),
    .seq_low_o             (seq_low),
    .seq_err_o             (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit tb_digit(input logic [7:0] b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  // Field-level model: walk tag=value fields, find the first tag 34 and
  // report the index of the byte that produces a result (or -1 if none).
  function automatic void ref_parse(input logic [7:0] m[$], input bit has_last,
                                    output int idx, output logic [1:0] err,
                                    output longint val);
    int     n;
    int     p;
    int     cnt;
    longint tag;
    n = m.size();
    p = 0;
    idx = -1;
    err = 2'd0;
    val = 0;
    if (n == 0) return;
    if (has_last && n == 1) begin idx = 0; err = 2'd1; return; end
    while (p < n) begin
      tag = 0;
      while (p < n && tb_digit(m[p])) begin
        if (has_last && p == n - 1) begin idx = p; err = 2'd1; return; end
        if (tag < 100000) tag = tag * 10 + longint'(m[p] - 8'h30);
        p++;
      end
      if (p >= n) return;
      if (has_last && p == n - 1) begin idx = p; err = 2'd1; return; end
      if (m[p] == 8'h3D && tag == 34) begin
        p++;
        cnt = 0;
        val = 0;
        while (p < n && tb_digit(m[p])) begin
          if (has_last && p == n - 1) begin idx = p; err = 2'd1; return; end
          cnt++;
          if (cnt <= MD) val = val * 10 + longint'(m[p] - 8'h30);
          p++;
        end
        if (p >= n) return;
        idx = p;
        if (m[p] != 8'h01 || cnt == 0)              err = 2'd2;
        else if (cnt > MD || val > 64'hFFFF_FFFF)  err = 2'd3;
        else                                         err = 2'd0;
        return;
      end
      p++;
      while (p < n && m[p] != 8'h01) begin
        if (has_last && p == n - 1) begin idx = p; err = 2'd1; return; end
        p++;
      end
      if (p >= n) return;
      if (has_last && p == n - 1) begin idx = p; err = 2'd1; return; end
      p++;
    end
  endfunction

  task automatic step(input bit v, input logic [7:0] b, input bit s, input bit l,
                      input bit exp_res, input logic [1:0] e, input logic [SW-1:0] val,
                      input logic [SW-1:0] exp_num);
    byte_valid = v;
    byte_d     = b;
    msg_start  = s;
    msg_last   = l;
    @(posedge clk);
    #1;
    if (exp_res && e == 2'd0) model_seq = val;
    check_eq("rnm_pulse", rnm, v && s);
    check_eq("seq_valid", seq_valid, exp_res);
    check_eq("seq_num", seq_num, model_seq);
    if (exp_res) begin
      check_eq("seq_err", seq_err, e);
      check_eq("seq_ok", seq_ok, e == 2'd0 && val == exp_num);
      check_eq("seq_gap", seq_gap, e == 2'd0 && val > exp_num);
      check_eq("seq_low", seq_low, e == 2'd0 && val < exp_num);
    end
  endtask

  task automatic send_msg(input string s, input bit has_last, input logic [SW-1:0] exp_num,
                          input bit with_start);
    logic [7:0] m[$];
    int         idx;
    logic [1:0] err;
    longint     val;
    for (int i = 0; i < s.len(); i++) m.push_back(s[i] == "|" ? 8'h01 : s[i]);
    ref_parse(m, has_last, idx, err, val);
    if (!with_start) idx = -1;
    expected = exp_num;
    $display("msg \"%s\" last=%0d start=%0d exp=%0d -> idx=%0d err=%0d val=%0d",
             s, has_last, with_start, exp_num, idx, err, val);
    for (int i = 0; i < m.size(); i++) begin
      while ($urandom_range(0, 3) == 0)
        step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 2'd0, '0, exp_num);
      step(1'b1, m[i], with_start && i == 0, has_last && i == m.size() - 1,
           i == idx, err, val[SW-1:0], exp_num);
    end
  endtask

  function automatic string num_str(input logic [SW-1:0] e);
    case ($urandom_range(0, 9))
      0, 1:    return $sformatf("%0d", e);
      2:       return $sformatf("%0d", e + SW'($urandom_range(1, 3)));
      3:       return $sformatf("%0d", e - SW'($urandom_range(1, 3)));
      4:       return $sformatf("%0d", $urandom);
      5:       return $urandom_range(0, 1) ? "4294967295" : "4294967296";
      6:       return $sformatf("000%0d", $urandom_range(0, 999));
      7:       return "";
      8:       return "12a";
      default: return "99999999999";
    endcase
  endfunction

  function automatic string other_field();
    case ($urandom_range(0, 6))
      0:       return "8=FIX.4.2";
      1:       return "35=A";
      2:       return "49=X";
      3:       return "340=5";
      4:       return "3=4";
      5:       return "x=1";
      default: return "34=999";
    endcase
  endfunction

  task automatic reset_pulse();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_valid", seq_valid, 1'b0);
    check_eq("rst_num", seq_num, '0);
    check_eq("rst_rnm", rnm, 1'b0);
    check_eq("rst_flags", {seq_ok, seq_gap, seq_low, seq_err}, 5'd0);
    model_seq = '0;
    #3 rst = 1'b0;
  endtask

  initial begin
    string         s;
    bit            has_last;
    int            nf;
    int            pos34;
    logic [SW-1:0] e;

    #2;
    check_eq("init_valid", seq_valid, 1'b0);
    check_eq("init_num", seq_num, '0);
    @(negedge clk);
    rst = 1'b0;

    send_msg("8=FIX.4.2|34=1024|", 1'b1, 1024, 1'b1);
    check_eq("req041_num", seq_num, 1024);
    send_msg("8=FIX.4.2|34=1024|", 1'b1, 1000, 1'b1);
    send_msg("8=FIX.4.2|34=1024|", 1'b1, 2000, 1'b1);
    send_msg("35=A|49=X|", 1'b1, 5, 1'b1);
    check_eq("req043_hold", seq_num, 1024);
    send_msg("34=12a|", 1'b1, 5, 1'b1);
    send_msg("34=|", 1'b1, 5, 1'b1);
    send_msg("34=99999999999|", 1'b1, 5, 1'b1);
    send_msg("34=4294967295|", 1'b1, 32'hFFFF_FFFF, 1'b1);
    check_eq("req044_max", seq_num, 32'hFFFF_FFFF);
    send_msg("34=5", 1'b0, 5, 1'b1);
    send_msg("34=7|", 1'b1, 7, 1'b1);
    check_eq("req045_num", seq_num, 7);
    send_msg("A", 1'b1, 7, 1'b1);
    send_msg("49=X|34=0042|34=9|", 1'b1, 42, 1'b1);

    send_msg("34=77|", 1'b1, 77, 1'b1);
    reset_pulse();
    send_msg("34=12", 1'b0, 12, 1'b1);
    reset_pulse();
    send_msg("34=3|", 1'b1, 3, 1'b0);
    send_msg("34=3|", 1'b1, 3, 1'b1);

    for (int k = 0; k < 150; k++) begin
      e  = $urandom;
      nf = $urandom_range(1, 4);
      pos34 = $urandom_range(0, nf);
      s = "";
      for (int f = 0; f < nf; f++) begin
        if (f == pos34) s = {s, "34=", num_str(e), "|"};
        else            s = {s, other_field(), "|"};
      end
      has_last = ($urandom_range(0, 9) != 0);
      if (!has_last && $urandom_range(0, 1) == 1)
        s = s.substr(0, $urandom_range(0, s.len() - 1));
      send_msg(s, has_last, e, 1'b1);
      if (has_last) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          step(1'b1, 8'($urandom_range(1, 127)), 1'b0, 1'($urandom), 1'b0, 2'd0, '0, e);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
